// File: rtl/gate4_sweep_checker.sv
// Exhaustive 4-input gate stimulus sweep with output checking.
// Holds each pattern SETTLE_CYCLES cycles, then samples and scores the gate.
module gate4_sweep_checker #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       gate_out,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] first_fail,
  output logic       first_fail_vld
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [7:0] CntLast = 8'(SETTLE_CYCLES - 1);

  state_t     state_q;
  logic [3:0] pat_q;
  logic [7:0] cnt_q;
  logic [1:0] mode_q;
  logic [4:0] err_q;
  logic [3:0] ff_q;
  logic       ffv_q;
  logic       done_q;
  logic       exp_d;
  logic       miss_d;

  always_comb begin
    exp_d = 1'b0;
    unique case (mode_q)
      2'b00: exp_d = |pat_q;
      2'b01: exp_d = &pat_q;
      2'b10: exp_d = ^pat_q;
      2'b11: exp_d = ~|pat_q;
      default: exp_d = 1'b0;
    endcase
    miss_d = (gate_out != exp_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      err_q   <= '0;
      ff_q    <= '0;
      ffv_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            pat_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= mode;
            err_q   <= '0;
            ffv_q   <= 1'b0;
            done_q  <= 1'b0;
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q == CntLast) state_q <= SAMPLE;
        end
        SAMPLE: begin
          if (miss_d) begin
            err_q <= err_q + 5'd1;
            if (!ffv_q) begin
              ff_q  <= pat_q;
              ffv_q <= 1'b1;
            end
          end
          cnt_q <= '0;
          // Pattern 15 is the last one; it stays on the gate inputs in DONE.
          if (pat_q == 4'hF) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            pat_q   <= pat_q + 4'd1;
            state_q <= SETTLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign {a, b, c, d}   = pat_q;
  assign busy           = (state_q == SETTLE) || (state_q == SAMPLE);
  assign done           = done_q;
  assign pass           = done_q && (err_q == 5'd0);
  assign err_count      = err_q;
  assign first_fail     = ff_q;
  assign first_fail_vld = ffv_q;

endmodule
